// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//   Two-requester arbiter that owns the select line of a 2:1 datapath mux
//   (sel=1 routes in_1, sel=0 routes in_2). Ownership goes to one requester at
//   a time. Ties are broken round-robin. A grant is preempted after MAX_HOLD
//   cycles when the other requester is waiting. Every ownership change passes
//   through GUARD dead cycles with no grant.
//
// Parameters
//   MAX_HOLD  cycles a grant may persist while the other request is pending (1..2^CNT_W-1)
//   GUARD     dead cycles between releasing one grant and asserting the next (1..2^CNT_W-1)
//   CNT_W     width of the hold and guard counters
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_1      requester 1 wants in_1 routed (held high for the whole transfer)
//   req_2      requester 2 wants in_2 routed
//   gnt_1      requester 1 owns the mux
//   gnt_2      requester 2 owns the mux
//   sel        mux select, 1 = in_1, 0 = in_2
//   busy       high in any state except IDLE
//   sw_pulse   one-cycle pulse with the first grant cycle whose sel differs from before
//   dbg_state  current FSM state (0 IDLE, 1 GNT1, 2 GNT2, 3 GUARD)
//
// Handshake: a request is a level. The arbiter answers with a registered grant
// one edge after it samples the request. The requester keeps req high for as
// long as it wants the mux. Dropping req releases the grant on the next edge.
// A request that falls before it is granted is forgotten.

module mux_sel_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int GUARD    = 1,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_1,
  input  logic       req_2,
  output logic       gnt_1,
  output logic       gnt_2,
  output logic       sel,
  output logic       busy,
  output logic       sw_pulse,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT1  = 2'd1,
    S_GNT2  = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  // last_q: requester granted most recently (0 = requester 1, 1 = requester 2)
  logic             last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] guard_q, guard_d;
  logic             gnt_1_q, gnt_1_d;
  logic             gnt_2_q, gnt_2_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             sw_pulse_q, sw_pulse_d;

  logic             pick_1, pick_2, arb_run;

  // Round-robin pick: on a tie the requester that was not served last wins.
  assign pick_1  = req_1 & (~req_2 | last_q);
  assign pick_2  = req_2 & (~req_1 | ~last_q);
  assign arb_run = (state_q == S_IDLE) ||
                   ((state_q == S_GUARD) && (guard_q == GUARD_LIM));

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_d     = hold_q;
    guard_d    = guard_q;
    gnt_1_d    = gnt_1_q;
    gnt_2_d    = gnt_2_q;
    sel_d      = sel_q;
    sw_pulse_d = 1'b0;

    case (state_q)
      S_GNT1: begin
        // The >= keeps preemption working even if the hold counter ran past
        // the limit while nobody else was waiting.
        if (!req_1 || (req_2 && (hold_q >= HOLD_LIM))) begin
          state_d = S_GUARD;
          gnt_1_d = 1'b0;
          guard_d = '0;
        end else if (hold_q != CNT_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_GNT2: begin
        if (!req_2 || (req_1 && (hold_q >= HOLD_LIM))) begin
          state_d = S_GUARD;
          gnt_2_d = 1'b0;
          guard_d = '0;
        end else if (hold_q != CNT_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (guard_q != GUARD_LIM) begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Arbitration runs in IDLE and on the last guard cycle. sel holds its
    // value through GUARD and only moves when a new grant is issued.
    if (arb_run) begin
      if (pick_1) begin
        state_d    = S_GNT1;
        gnt_1_d    = 1'b1;
        sel_d      = 1'b1;
        last_d     = 1'b0;
        hold_d     = '0;
        sw_pulse_d = ~sel_q;
      end else if (pick_2) begin
        state_d    = S_GNT2;
        gnt_2_d    = 1'b1;
        sel_d      = 1'b0;
        last_d     = 1'b1;
        hold_d     = '0;
        sw_pulse_d = sel_q;
      end else begin
        state_d = S_IDLE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;   // as if requester 2 went last: requester 1 wins the first tie
      hold_q     <= '0;
      guard_q    <= '0;
      gnt_1_q    <= 1'b0;
      gnt_2_q    <= 1'b0;
      sel_q      <= 1'b0;
      busy_q     <= 1'b0;
      sw_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      guard_q    <= guard_d;
      gnt_1_q    <= gnt_1_d;
      gnt_2_q    <= gnt_2_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      sw_pulse_q <= sw_pulse_d;
    end
  end

  assign gnt_1     = gnt_1_q;
  assign gnt_2     = gnt_2_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign sw_pulse  = sw_pulse_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed testbench for mux_sel_arbiter with MAX_HOLD=4, GUARD=1.
// Output vectors are packed as {gnt_1, gnt_2, sel, busy, sw_pulse}.

module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int GUARD    = 1;

  logic       clk;
  logic       rst;
  logic       req_1;
  logic       req_2;
  logic       gnt_1;
  logic       gnt_2;
  logic       sel;
  logic       busy;
  logic       sw_pulse;
  logic [1:0] dbg_state;

  int n_checks;
  int n_pass;

  mux_sel_arbiter #(
    .MAX_HOLD(MAX_HOLD),
    .GUARD   (GUARD),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_1    (req_1),
    .req_2    (req_2),
    .gnt_1    (gnt_1),
    .gnt_2    (gnt_2),
    .sel      (sel),
    .busy     (busy),
    .sw_pulse (sw_pulse),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {3'b000, gnt_1, gnt_2, sel, busy, sw_pulse}, {3'b000, exp});
  endtask

  logic [4:0] tie_exp [13];
  logic       r2_at_edge, r1_at_edge;
  int         run_1, run_2;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    req_1    = 1'b0;
    req_2    = 1'b0;
    rst      = 1'b0;
    #1 rst   = 1'b1;
    #2;
    chk_out("reset_outputs", 5'b00000);
    chk("reset_state", {6'd0, dbg_state}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_out("idle_after_reset", 5'b00000);

    // single requester: 5 grant cycles, one sw_pulse, then GUARD and IDLE
    req_1 = 1'b1;
    tick();
    chk_out("single_c1", 5'b10111);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk_out($sformatf("single_c%0d", i), 5'b10110);
    end
    req_1 = 1'b0;
    tick();
    chk_out("single_guard", 5'b00110);
    chk("single_guard_state", {6'd0, dbg_state}, 8'd3);
    tick();
    chk_out("single_idle", 5'b00100);

    // tie after reset: reset between edges, then both requests together
    #2 rst = 1'b1;
    #1;
    chk_out("tie_reset", 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    tie_exp = '{5'b10111, 5'b10110, 5'b10110, 5'b10110, 5'b00110,
                5'b01011, 5'b01010, 5'b01010, 5'b01010, 5'b00010,
                5'b10111, 5'b00110, 5'b00100};
    req_1 = 1'b1;
    req_2 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 11) begin
        req_1 = 1'b0;
        req_2 = 1'b0;
      end
      tick();
      chk_out($sformatf("tie_c%0d", i), tie_exp[i]);
    end

    // voluntary release: gnt_2 for 3 cycles, req_1 rises one cycle early
    req_2 = 1'b1;
    tick();
    chk_out("rel_g2_c1", 5'b01011);
    tick();
    chk_out("rel_g2_c2", 5'b01010);
    req_1 = 1'b1;
    tick();
    chk_out("rel_g2_c3", 5'b01010);
    req_2 = 1'b0;
    tick();
    chk_out("rel_guard", 5'b00010);
    tick();
    chk_out("rel_g1_entry", 5'b10111);
    tick();
    chk_out("rel_g1_c2", 5'b10110);
    req_1 = 1'b0;
    tick();
    chk_out("rel_g1_guard", 5'b00110);
    tick();
    chk_out("rel_idle", 5'b00100);

    // dropped request: req_1 pulses during GNT2 and never gets a grant
    req_2 = 1'b1;
    tick();
    chk_out("drop_g2_c1", 5'b01011);
    req_1 = 1'b1;
    tick();
    chk_out("drop_g2_c2", 5'b01010);
    req_1 = 1'b0;
    req_2 = 1'b0;
    tick();
    chk_out("drop_guard", 5'b00010);
    tick();
    chk_out("drop_idle", 5'b00000);
    tick();
    chk_out("drop_idle2", 5'b00000);
    chk("drop_state", {6'd0, dbg_state}, 8'd0);

    // mid-grant reset, then both requests high: requester 1 wins
    req_1 = 1'b1;
    tick();
    chk_out("mr_g1_c1", 5'b10111);
    req_2 = 1'b1;
    tick();
    chk_out("mr_g1_c2", 5'b10110);
    #2 rst = 1'b1;
    #1;
    chk_out("mr_async_reset", 5'b00000);
    chk("mr_reset_state", {6'd0, dbg_state}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_out("mr_g1_after", 5'b10111);
    tick();
    chk_out("mr_g1_hold", 5'b10110);

    // random requests with invariant checks
    run_1 = 0;
    run_2 = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) req_1 = ~req_1;
      if ($urandom_range(0, 7) == 0) req_2 = ~req_2;
      r1_at_edge = req_1;
      r2_at_edge = req_2;
      tick();
      chk("rnd_exclusive", {7'd0, gnt_1 & gnt_2}, 8'd0);
      if (gnt_1) chk("rnd_sel_g1", {7'd0, sel}, 8'd1);
      if (gnt_2) chk("rnd_sel_g2", {7'd0, sel}, 8'd0);
      run_1 = (gnt_1 && r2_at_edge) ? run_1 + 1 : 0;
      run_2 = (gnt_2 && r1_at_edge) ? run_2 + 1 : 0;
      chk("rnd_hold_1", {7'd0, run_1 > MAX_HOLD}, 8'd0);
      chk("rnd_hold_2", {7'd0, run_2 > MAX_HOLD}, 8'd0);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
